// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
//   Shared types and helpers for the adder_arbiter block.
//   - state_t : sequencer states (2-bit encoding)
//   - rr_next : round-robin pointer increment with wrap at nreq-1
// -----------------------------------------------------------------------------
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pointer after granting idx: the requester just served goes to the back
  // of the queue. Explicit compare instead of modulo so non-power-of-two
  // requester counts wrap correctly.
  function automatic int unsigned rr_next(input int unsigned idx,
                                          input int unsigned nreq);
    return (idx == nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   N-bit unsigned ripple-carry adder, purely combinational.
//   Ports:
//     a, b  in  N  operands
//     sum   out N  (a + b) mod 2^N
//     cout  out 1  carry out of bit N-1
// -----------------------------------------------------------------------------
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  always_comb begin
    c[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Scans requesters starting at rr_ptr,
//   wrapping at NREQ-1, and grants the first valid one.
//   Ports:
//     req_valid  in  NREQ  per-requester valid
//     rr_ptr     in  IDW   highest-priority requester this cycle
//     grant      out NREQ  one-hot grant, zero when nothing is valid
//     grant_id   out IDW   encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW:0]   scan;
  logic [IDW-1:0] idx;
  logic           found;

  // NOTE: every output and temporary gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan     = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so rr_ptr + k cannot overflow before the wrap.
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      idx = scan[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found         = 1'b1;
        grant[idx]    = 1'b1;
        grant_id      = idx;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Shares one N-bit ripple adder among NREQ requesters. Round-robin grant,
//   valid/ready on both sides, one registered result tagged with the id of
//   the requester that produced it. One operation per three cycles at best:
//   IDLE (grant + capture) -> BUSY (add + register) -> DONE (hold result).
//
//   Ports:
//     clk        in   1       rising-edge clock
//     rst        in   1       asynchronous reset, active-high
//     req_valid  in   NREQ    per-requester operand valid
//     req_a      in   NREQ*N  operand a, requester i at [i*N +: N]
//     req_b      in   NREQ*N  operand b, same packing
//     req_ready  out  NREQ    one-hot-or-zero accept, only in IDLE
//     res_valid  out  1       result valid (state DONE)
//     res_ready  in   1       result consumer ready
//     res_sum    out  N       registered sum
//     res_carry  out  1       registered carry-out
//     res_id     out  IDW     requester that produced the result
//
//   Build option ADDER_ARB_SAT_EN: when defined, an overflowing sum
//   saturates to all ones (res_carry still reports the overflow). When
//   undefined the sum wraps. Timing is identical in both builds.
// -----------------------------------------------------------------------------
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id
);

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   a_q, b_q;
  logic [IDW-1:0] id_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            req_hs;
  logic [N-1:0]    add_sum;
  logic            add_cout;
  logic [N-1:0]    sum_final;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  adder #(
    .N (N)
  ) u_adder (
    .a    (a_q),
    .b    (b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
`ifdef ADDER_ARB_SAT_EN
    sum_final = add_cout ? {N{1'b1}} : add_sum;
`else
    sum_final = add_sum;
`endif
  end

  // Grant is only visible in IDLE. It is also masked by rst so that no
  // requester sees an accept while the block is held in reset.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (!rst) req_ready = grant;
        if (|(req_valid & req_ready)) state_nx = BUSY;
      end
      BUSY:    state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_hs    = (state == IDLE) && (|(req_valid & req_ready));
  assign res_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
    end else begin
      state <= state_nx;
      if (req_hs) begin
        a_q    <= req_a[grant_id*N +: N];
        b_q    <= req_b[grant_id*N +: N];
        id_q   <= grant_id;
        rr_ptr <= IDW'(rr_next(32'(grant_id), NREQ));
      end
      if (state == BUSY) begin
        res_sum   <= sum_final;
        res_carry <= add_cout;
        res_id    <= id_q;
      end
    end
  end

endmodule
